// File: rtl/uart_pkg.sv
// uart_pkg: shared types, oversampling constants and parity helper for the UART core.
package uart_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, ODD = 2'd1, EVEN = 2'd2} parity_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    function automatic logic parity_bit(input logic [8:0] data, input parity_e mode);
        return (mode == ODD) ? ~^data : (mode == EVEN) ? ^data : 1'b0;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running modulo-CLK_DIV counter producing the 16x oversample tick.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CLK_DIV - 1);
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else cnt <= tick ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: parameterised UART with shared baud tick, TX and 16x-oversampling RX.
// Optional macro UART_LOOPBACK_EN adds a loopback input routing TX back into RX.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CLK_DIV   = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    input  logic                 serial_in,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    localparam int BW = $clog2(DATA_BITS);
    localparam parity_e PMODE = parity_e'(PARITY);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID = 4'(MID_SAMPLE - 1);

    logic tick;
    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

    tx_state_e tx_state, tx_next;
    logic [3:0] tx_cnt;
    logic [BW-1:0] tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic tx_par, tx_line, tx_end;
    assign tx_end = tick && tx_cnt == LAST;
    assign tx_ready = tx_state == TX_IDLE;

    always_comb begin
        tx_next = tx_state;
        tx_line = 1'b1;
        case (tx_state)
            TX_IDLE: tx_next = tx_valid ? TX_START : TX_IDLE;
            TX_START: begin
                tx_line = 1'b0;
                if (tx_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_end && tx_bit == BW'(DATA_BITS - 1)) tx_next = (PMODE != NONE) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_end) tx_next = TX_STOP;
            end
            TX_STOP: if (tx_end && tx_bit == BW'(STOP_BITS - 1)) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // tx_bit restarts at every state change so it indexes data bits and stop bits alike
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                if (tx_valid) begin
                    tx_shift <= tx_data;
                    tx_par   <= parity_bit(9'(tx_data), PMODE);
                end
            end else if (tick) begin
                tx_cnt <= tx_cnt + 4'd1;
                if (tx_end) begin
                    tx_bit <= (tx_next != tx_state) ? '0 : tx_bit + BW'(1);
                    if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
                end
            end
        end
    end

    logic rx_raw, sync1, sync2, rx_prev, rx_sample, rx_pbad;
    rx_state_e rx_state, rx_next;
    logic [3:0] rx_cnt;
    logic [BW-1:0] rx_bit;
    logic [DATA_BITS-1:0] rx_shift;

`ifdef UART_LOOPBACK_EN
    assign rx_raw = loopback ? tx_line : serial_in;
    assign serial_out = loopback | tx_line;
`else
    assign rx_raw = serial_in;
    assign serial_out = tx_line;
`endif

    // START samples at its midpoint; every later sample lands a full bit later
    assign rx_sample = tick && rx_cnt == ((rx_state == RX_START) ? MID : LAST);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_prev && !sync2) rx_next = RX_START;
            RX_START: if (rx_sample) rx_next = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA: if (rx_sample && rx_bit == BW'(DATA_BITS - 1)) rx_next = (PMODE != NONE) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP: if (rx_sample) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_pbad     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync1       <= rx_raw;
            sync2       <= sync1;
            rx_prev     <= sync2;
            rx_state    <= rx_next;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
            end else if (tick) rx_cnt <= rx_sample ? '0 : rx_cnt + 4'd1;
            if (rx_sample && rx_state == RX_DATA) begin
                rx_shift <= {sync2, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + BW'(1);
            end
            if (rx_sample && rx_state == RX_PARITY) rx_pbad <= sync2 != parity_bit(9'(rx_shift), PMODE);
            if (rx_sample && rx_state == RX_STOP) begin
                rx_data     <= rx_shift;
                rx_valid    <= 1'b1;
                parity_err  <= (PMODE != NONE) && rx_pbad;
                frame_err   <= !sync2;
                overrun_err <= rx_valid && !rx_ready;
            end else if (rx_ready) rx_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: scoreboard bench with a no-parity (u0) and an even-parity (u2) UART, CLK_DIV=4.
module tb_uart_core_param;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] txd0 = 8'h00, txd2 = 8'h00, rd0, rd2;
    logic txv0 = 1'b0, txv2 = 1'b0, si0 = 1'b1, si2 = 1'b1, rr0 = 1'b1, rr2 = 1'b1;
    logic rdy0, so0, rv0, pe0, fe0, oe0, rdy2, so2, rv2, pe2, fe2, oe2;
`ifdef UART_LOOPBACK_EN
    logic lb0 = 1'b0, lb2 = 1'b0;
`endif

    uart_core_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_DIV(4)) u0 (
        .clk(clk), .reset(reset), .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy0),
        .serial_out(so0), .serial_in(si0),
`ifdef UART_LOOPBACK_EN
        .loopback(lb0),
`endif
        .rx_data(rd0), .rx_valid(rv0), .rx_ready(rr0),
        .parity_err(pe0), .frame_err(fe0), .overrun_err(oe0));

    uart_core_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLK_DIV(4)) u2 (
        .clk(clk), .reset(reset), .tx_data(txd2), .tx_valid(txv2), .tx_ready(rdy2),
        .serial_out(so2), .serial_in(si2),
`ifdef UART_LOOPBACK_EN
        .loopback(lb2),
`endif
        .rx_data(rd2), .rx_valid(rv2), .rx_ready(rr2),
        .parity_err(pe2), .frame_err(fe2), .overrun_err(oe2));

    typedef struct {logic [7:0] data; logic pe; logic fe; logic oe;} rx_exp_t;
    typedef struct {logic [10:0] bits; int n;} tx_exp_t;
    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];
    int n_checks = 0, n_fail = 0;
    logic tx_sel = 1'b0, tx_mon_en = 1'b1, tx_busy = 1'b0;
    logic mon_so, mon_rdy;
    assign mon_so = tx_sel ? so2 : so0;
    assign mon_rdy = tx_sel ? rdy2 : rdy0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RX monitor: a new payload or any error pulse is one event
    logic rv_prev = 1'b0;
    rx_exp_t rx_e;
    always @(negedge clk) begin
        if (!reset && ((rv2 && !rv_prev) || pe2 || fe2 || oe2)) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: data %0h errs %b%b%b with nothing expected", rd2, pe2, fe2, oe2);
            end else begin
                rx_e = rx_q.pop_front();
                check("rx_data", 32'(rd2), 32'(rx_e.data));
                check("rx_valid", 32'(rv2), 32'd1);
                check("rx_errs", 32'({pe2, fe2, oe2}), 32'({rx_e.pe, rx_e.fe, rx_e.oe}));
            end
        end
        rv_prev <= rv2;
    end

    // TX monitor: start edge, sample each bit near its centre, then time tx_ready
    logic tx_prev = 1'b1;
    tx_exp_t tx_e;
    logic [10:0] got;
    int c;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_mon_en && tx_prev && !mon_so) begin
                tx_busy = 1'b1;
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: start bit seen with nothing expected");
                end else begin
                    tx_e = tx_q.pop_front();
                    got = '0;
                    c = 0;
                    for (int k = 0; k < tx_e.n; k++) begin
                        while (c < 32 + 64 * k) begin
                            @(negedge clk);
                            c++;
                        end
                        got[k] = mon_so;
                    end
                    while (!mon_rdy && c < 2000) begin
                        @(negedge clk);
                        c++;
                    end
                    check("tx_bits", 32'(got), 32'(tx_e.bits));
                    n_checks++;
                    if (c < 64 * tx_e.n - 3 || c > 64 * tx_e.n) begin
                        n_fail++;
                        $display("FAIL tx_len: tx_ready after %0d clk expected %0d..%0d", c, 64 * tx_e.n - 3, 64 * tx_e.n);
                    end
                end
                tx_busy = 1'b0;
            end
            tx_prev = mon_so;
        end
    end

`ifdef UART_LOOPBACK_EN
    logic lb_watch = 1'b0;
    int so_low = 0;
    always @(negedge clk) if (lb_watch && !so2) so_low <= so_low + 1;
`endif

    task automatic tx_send(input logic sel, input logic [7:0] d);
        @(negedge clk);
        if (sel) begin txd2 = d; txv2 = 1'b1; end
        else begin txd0 = d; txv0 = 1'b1; end
        @(negedge clk);
        txv0 = 1'b0;
        txv2 = 1'b0;
        txd0 = ~d;
        txd2 = ~d;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            si2 = f[k];
            repeat (64) @(negedge clk);
        end
        si2 = 1'b1;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0 || tx_busy) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(rx_q.size() + tx_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_serial_out0", 32'(so0), 32'd1);
        check("rst_serial_out2", 32'(so2), 32'd1);
        check("rst_tx_ready", 32'({rdy0, rdy2}), 32'b11);
        check("rst_rx_valid", 32'({rv0, rv2}), 32'b00);
        check("rst_rx_data", 32'({rd0, rd2}), 32'd0);
        check("rst_errs", 32'({pe0, fe0, oe0, pe2, fe2, oe2}), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        tx_sel = 1'b0;
        tx_q.push_back('{11'({1'b1, 8'hA5, 1'b0}), 10});
        tx_send(1'b0, 8'hA5);
        drain("drain_tx_a5");
        tx_sel = 1'b1;
        tx_q.push_back('{{1'b1, 1'b1, 8'h07, 1'b0}, 11});
        tx_send(1'b1, 8'h07);
        drain("drain_tx_07");

        rx_q.push_back('{8'h07, 1'b1, 1'b0, 1'b0});
        rx_send(8'h07, 1'b0, 1'b1);
        rx_q.push_back('{8'h5A, 1'b0, 1'b1, 1'b0});
        rx_send(8'h5A, 1'b0, 1'b0);
        repeat (64) @(negedge clk);
        rx_q.push_back('{8'hE1, 1'b0, 1'b0, 1'b0});
        rx_send(8'hE1, 1'b0, 1'b1);
        si2 = 1'b0;
        repeat (8) @(negedge clk);
        si2 = 1'b1;
        repeat (100) @(negedge clk);
        rx_q.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
        rx_send(8'h81, 1'b0, 1'b1);
        drain("drain_rx_basic");

        rr2 = 1'b0;
        rx_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
        rx_q.push_back('{8'hC3, 1'b0, 1'b0, 1'b1});
        rx_send(8'h3C, 1'b0, 1'b1);
        rx_send(8'hC3, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        drain("drain_overrun");
        check("overrun_data", 32'(rd2), 32'h0C3);
        check("overrun_valid_held", 32'(rv2), 32'd1);
        rr2 = 1'b1;
        @(negedge clk);
        check("valid_clear", 32'(rv2), 32'd0);

        tx_mon_en = 1'b0;
        tx_send(1'b0, 8'h00);
        repeat (200) @(negedge clk);
        check("mid_frame_low", 32'(so0), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_serial_out", 32'(so0), 32'd1);
        check("reset_tx_ready", 32'(rdy0), 32'd1);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tx_sel = 1'b0;
        tx_mon_en = 1'b1;
        tx_q.push_back('{11'({1'b1, 8'h55, 1'b0}), 10});
        tx_send(1'b0, 8'h55);
        drain("drain_tx_55");

`ifdef UART_LOOPBACK_EN
        lb2 = 1'b1;
        repeat (4) @(negedge clk);
        lb_watch = 1'b1;
        rx_q.push_back('{8'h96, 1'b0, 1'b0, 1'b0});
        tx_send(1'b1, 8'h96);
        drain("drain_loopback");
        c = 0;
        while (!rdy2 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("loopback_tx_done", 32'(rdy2), 32'd1);
        lb_watch = 1'b0;
        check("loopback_serial_out_low_cycles", 32'(so_low), 32'd0);
        lb2 = 1'b0;
`endif

        drain("drain_final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
